// File: rtl/seq_detect_ctrl.sv
// Run-time controller for the serial pattern detector: holds the programmable
// pattern, shifts qualified input bits into a history and schedules detection runs.
module seq_detect_ctrl #(
  parameter int MAXLEN = 8,
  parameter int LENW   = 4,
  parameter int CNTW   = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Cfg_Load,
  input  logic [MAXLEN-1:0] Cfg_Pattern,
  input  logic [LENW-1:0]   Cfg_Len,
  input  logic              Cfg_Overlap,
  input  logic [CNTW-1:0]   Cfg_Limit,
  output logic              Cfg_Err,
  input  logic              Start,
  input  logic              Abort,
  input  logic              Din,
  input  logic              Din_Valid,
  output logic              Y,
  output logic [CNTW-1:0]   Match_Count,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HIT, S_DONE} state_t;

  localparam logic [MAXLEN-1:0] DEF_PAT = MAXLEN'(4'b1101);
  localparam logic [LENW-1:0]   DEF_LEN = LENW'(4);

  state_t            state_q, state_d;
  logic [MAXLEN-1:0] pat_q, pat_d;
  logic [MAXLEN-1:0] hist_q, hist_d, hist_new;
  logic [MAXLEN-1:0] len_mask;
  logic [LENW-1:0]   len_q, len_d;
  logic [LENW-1:0]   seen_q, seen_d, seen_new;
  logic [LENW:0]     seen_inc;
  logic              ovl_q, ovl_d;
  logic              lim_hit_q, lim_hit_d;
  logic [CNTW-1:0]   lim_q, lim_d;
  logic [CNTW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic              cfg_err_q, cfg_err_d;
  logic              y_q, busy_q, done_q;
  logic              len_bad, enough_bits, match;

  // Only the low Len bits of history and pattern take part in the compare.
  for (genvar gi = 0; gi < MAXLEN; gi++) begin : g_mask
    assign len_mask[gi] = ({1'b0, len_q} > (LENW+1)'(gi));
  end

  always_comb begin
    hist_new    = {hist_q[MAXLEN-2:0], Din};
    seen_inc    = {1'b0, seen_q} + (LENW+1)'(1);
    enough_bits = (seen_inc >= {1'b0, len_q});
    seen_new    = enough_bits ? len_q : seen_inc[LENW-1:0];
    match       = enough_bits && ((hist_new & len_mask) == (pat_q & len_mask));
    cnt_inc     = (cnt_q == {CNTW{1'b1}}) ? cnt_q : cnt_q + CNTW'(1);
    len_bad     = (Cfg_Len == '0) || ({1'b0, Cfg_Len} > (LENW+1)'(MAXLEN));

    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    lim_d     = lim_q;
    hist_d    = hist_q;
    seen_d    = seen_q;
    cnt_d     = cnt_q;
    lim_hit_d = lim_hit_q;
    cfg_err_d = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Cfg_Load) begin
          if (len_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            pat_d = Cfg_Pattern;
            len_d = Cfg_Len;
            ovl_d = Cfg_Overlap;
            lim_d = Cfg_Limit;
          end
          if (state_q == S_DONE) state_d = S_IDLE;
        end
        if (Start) begin
          hist_d    = '0;
          seen_d    = '0;
          cnt_d     = '0;
          lim_hit_d = 1'b0;
          state_d   = S_RUN;
        end
      end
      S_RUN, S_HIT: begin
        if (Abort) begin
          lim_hit_d = 1'b0;
          state_d   = S_IDLE;
        end else if (state_q == S_HIT && lim_hit_q) begin
          // The limiting match gets its HIT cycle; input in that cycle is dropped.
          lim_hit_d = 1'b0;
          state_d   = S_DONE;
        end else if (Din_Valid) begin
          hist_d  = hist_new;
          seen_d  = seen_new;
          state_d = S_RUN;
          if (match) begin
            cnt_d   = cnt_inc;
            state_d = S_HIT;
            if (!ovl_q) begin
              hist_d = '0;
              seen_d = '0;
            end
            if (lim_q != '0 && cnt_inc == lim_q) lim_hit_d = 1'b1;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      pat_q     <= DEF_PAT;
      len_q     <= DEF_LEN;
      ovl_q     <= 1'b1;
      lim_q     <= '0;
      hist_q    <= '0;
      seen_q    <= '0;
      cnt_q     <= '0;
      lim_hit_q <= 1'b0;
      cfg_err_q <= 1'b0;
      y_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      lim_q     <= lim_d;
      hist_q    <= hist_d;
      seen_q    <= seen_d;
      cnt_q     <= cnt_d;
      lim_hit_q <= lim_hit_d;
      cfg_err_q <= cfg_err_d;
      y_q       <= (state_d == S_HIT);
      busy_q    <= (state_d == S_RUN) || (state_d == S_HIT);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign Y           = y_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Cfg_Err     = cfg_err_q;
  assign Match_Count = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: a bit-queue reference model predicts
// Y pulses and Cfg_Err pulses; a negedge monitor pops and compares them.
module tb_seq_detect_ctrl;
  localparam int MAXLEN = 8;
  localparam int LENW   = 4;
  localparam int CNTW   = 8;

  logic              Clock = 1'b0;
  logic              Reset = 1'b0;
  logic              Cfg_Load = 1'b0;
  logic [MAXLEN-1:0] Cfg_Pattern = '0;
  logic [LENW-1:0]   Cfg_Len = '0;
  logic              Cfg_Overlap = 1'b0;
  logic [CNTW-1:0]   Cfg_Limit = '0;
  logic              Cfg_Err;
  logic              Start = 1'b0;
  logic              Abort = 1'b0;
  logic              Din = 1'b0;
  logic              Din_Valid = 1'b0;
  logic              Y;
  logic [CNTW-1:0]   Match_Count;
  logic              Busy;
  logic              Done;

  seq_detect_ctrl #(.MAXLEN(MAXLEN), .LENW(LENW), .CNTW(CNTW)) dut (
    .Clock(Clock), .Reset(Reset), .Cfg_Load(Cfg_Load), .Cfg_Pattern(Cfg_Pattern),
    .Cfg_Len(Cfg_Len), .Cfg_Overlap(Cfg_Overlap), .Cfg_Limit(Cfg_Limit),
    .Cfg_Err(Cfg_Err), .Start(Start), .Abort(Abort), .Din(Din), .Din_Valid(Din_Valid),
    .Y(Y), .Match_Count(Match_Count), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {int stamp; int count;} ev_t;
  ev_t y_q[$];
  int  err_q[$];

  typedef enum {M_IDLE, M_RUN, M_LIMW, M_DONE} mstate_t;
  mstate_t     m_state;
  bit          bits_q[$];
  logic [7:0]  m_pat;
  int          m_len, m_lim, m_cnt;
  bit          m_ovl;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every Y / Cfg_Err high cycle must match the next predicted event.
  always @(negedge Clock) begin
    ev_t e;
    if (Reset) begin
      if (Y) begin
        n_tests++;
        if (y_q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_y: Y=1 with no match expected (cycle %0d)", cyc);
        end else begin
          e = y_q.pop_front();
          check("y_cycle", cyc, e.stamp);
          check("y_count", int'(Match_Count), e.count);
        end
      end
      if (Cfg_Err) begin
        n_tests++;
        if (err_q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_cfg_err: Cfg_Err=1 unexpected (cycle %0d)", cyc);
        end else begin
          check("cfg_err_cycle", cyc, err_q.pop_front());
        end
      end
    end
  end

  function automatic bit tail_match();
    for (int i = 0; i < m_len; i++)
      if (bits_q[bits_q.size() - m_len + i] != m_pat[m_len - 1 - i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    bits_q.delete();
    m_pat = 8'b0000_1101;
    m_len = 4;
    m_ovl = 1'b1;
    m_lim = 0;
    m_cnt = 0;
  endtask

  // Reference model: applies the current input set, predicting the cycle after.
  task automatic model_apply();
    ev_t e;
    int  stamp;
    stamp = cyc + 1;
    case (m_state)
      M_IDLE, M_DONE: begin
        if (Cfg_Load) begin
          if (Cfg_Len == 0 || Cfg_Len > MAXLEN) err_q.push_back(stamp);
          else begin
            m_pat = Cfg_Pattern; m_len = int'(Cfg_Len);
            m_ovl = Cfg_Overlap; m_lim = int'(Cfg_Limit);
          end
          if (m_state == M_DONE) m_state = M_IDLE;
        end
        if (Start) begin
          bits_q.delete();
          m_cnt   = 0;
          m_state = M_RUN;
        end
      end
      M_RUN: begin
        if (Abort) m_state = M_IDLE;
        else if (Din_Valid) begin
          bits_q.push_back(Din);
          if (bits_q.size() > MAXLEN) bits_q.delete(0);
          if (bits_q.size() >= m_len && tail_match()) begin
            if (m_cnt < 255) m_cnt++;
            e.stamp = stamp; e.count = m_cnt;
            y_q.push_back(e);
            if (!m_ovl) bits_q.delete();
            if (m_lim != 0 && m_cnt == m_lim) m_state = M_LIMW;
          end
        end
      end
      M_LIMW: m_state = Abort ? M_IDLE : M_DONE;
      default: m_state = M_IDLE;
    endcase
  endtask

  task automatic tick();
    model_apply();
    @(posedge Clock);
    #1;
    Cfg_Load = 1'b0; Start = 1'b0; Abort = 1'b0; Din_Valid = 1'b0;
    check("busy", int'(Busy), int'(m_state == M_RUN || m_state == M_LIMW));
    check("done", int'(Done), int'(m_state == M_DONE));
    check("match_count", int'(Match_Count), m_cnt);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic start_run();
    Start = 1'b1; tick();
  endtask

  task automatic abort_run();
    Abort = 1'b1; tick();
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input bit ovl,
                      input logic [7:0] lim);
    Cfg_Load = 1'b1; Cfg_Pattern = pat; Cfg_Len = len; Cfg_Overlap = ovl; Cfg_Limit = lim;
    tick();
  endtask

  task automatic send(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      Din = v[i]; Din_Valid = 1'b1; tick();
    end
  endtask

  task automatic drain();
    idle(3);
    check("y_pending", y_q.size(), 0);
    check("err_pending", err_q.size(), 0);
  endtask

  initial begin
    model_reset();
    #1;
    check("rst_y", int'(Y), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_done", int'(Done), 0);
    check("rst_cfg_err", int'(Cfg_Err), 0);
    check("rst_count", int'(Match_Count), 0);
    #11 Reset = 1'b1;
    @(posedge Clock); #1;

    // Default pattern 1101, single match
    start_run(); send(16'b1101, 4); drain();
    // Overlap on then off
    abort_run(); start_run(); send(16'b1101101, 7); drain();
    check("overlap_count", int'(Match_Count), 2);
    abort_run(); load(8'b1101, 4, 1'b0, 8'd0); start_run(); send(16'b1101101, 7); drain();
    check("no_overlap_count", int'(Match_Count), 1);
    abort_run(); load(8'b1101, 4, 1'b1, 8'd0);
    // Gaps in Din_Valid
    start_run(); send(16'b11, 2); idle(3); send(16'b01, 2); drain();
    // Match limit 2 -> DONE, then restart clears count
    abort_run(); load(8'b1101, 4, 1'b1, 8'd2); start_run();
    send(16'b1101_1101_1101, 12); drain();
    check("limit_done", int'(Done), 1);
    start_run(); check("restart_count", int'(Match_Count), 0);
    abort_run();
    // Illegal length, load gating in RUN, Len=1
    load(8'b0110, 4'd0, 1'b1, 8'd0);
    load(8'b1101, 4'd9, 1'b1, 8'd0);
    start_run(); send(16'b1101, 4);
    load(8'b0110, 4, 1'b1, 8'd0); send(16'b0110, 4); send(16'b1101, 4); drain();
    abort_run(); load(8'b1, 4'd1, 1'b1, 8'd0); start_run(); send(16'b111, 3); drain();
    check("len1_count", int'(Match_Count), 3);
    abort_run(); load(8'b1101, 4, 1'b1, 8'd0);
    // Abort together with final bit
    start_run(); send(16'b110, 3); Din = 1'b1; Din_Valid = 1'b1; Abort = 1'b1; tick(); drain();
    check("abort_count", int'(Match_Count), 0);
    // Async reset mid-run
    load(8'b0110, 4, 1'b0, 8'd0);
    start_run(); send(16'b0110, 4); send(16'b01, 2);
    #2 Reset = 1'b0;
    #1;
    check("midrst_y", int'(Y), 0);
    check("midrst_busy", int'(Busy), 0);
    check("midrst_count", int'(Match_Count), 0);
    model_reset(); y_q.delete(); err_q.delete();
    #1 Reset = 1'b1;
    @(posedge Clock); #1;
    start_run(); send(16'b1101101, 7); drain();
    check("default_after_reset", int'(Match_Count), 2);

    // Randomized phase
    for (int it = 0; it < 3000; it++) begin
      int r;
      r = $urandom_range(0, 99);
      Din = 1'($urandom_range(0, 1));
      Din_Valid = ($urandom_range(0, 3) != 0);
      if (r < 4) begin
        Cfg_Load    = 1'b1;
        Cfg_Pattern = 8'($urandom);
        Cfg_Len     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15) % 16 * (r & 1))
                                                  : 4'($urandom_range(1, 4));
        Cfg_Overlap = 1'($urandom_range(0, 1));
        Cfg_Limit   = 8'($urandom_range(0, 3));
        Start       = ($urandom_range(0, 3) == 0);
      end else if (r < 9) begin
        Start = 1'b1;
      end else if (r < 11) begin
        Abort = 1'b1;
      end
      tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
